// File: rtl/cla_adder_seq_if.sv
// Operand/result bundle for cla_adder_seq: start handshake, operands, and registered result.
interface cla_adder_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovr;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  s, cout, ovr, busy, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output s, cout, ovr, busy, done
    );
endinterface

// File: rtl/cla_adder_seq.sv
// Multi-cycle adder: one GROUP-bit carry-lookahead slice per cycle, LSB group first.
// Optional subtract support is compiled in when CLA_ADDER_SEQ_SUB_EN is defined.
module cla_adder_seq #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_adder_seq_if.slave  bus
);
    localparam int NG    = WIDTH / GROUP;
    localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovr;
    logic [IDX_W-1:0] r_idx;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [31:0]      w_base;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP:0]   w_c;
    logic [GROUP-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    // Every carry is a flat sum of products over p, g and the incoming carry.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           t;
        logic           pp;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & c0);
        end
        return c;
    endfunction

`ifdef CLA_ADDER_SEQ_SUB_EN
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.cin ^ bus.sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.sub;
    assign w_b_eff      = bus.b;
    assign w_cin_eff    = bus.cin;
`endif

    assign w_base    = 32'(r_idx) * 32'(GROUP);
    assign w_a_sh    = r_a >> w_base;
    assign w_b_sh    = r_b >> w_base;
    assign w_p       = w_a_sh[GROUP-1:0] ^ w_b_sh[GROUP-1:0];
    assign w_g       = w_a_sh[GROUP-1:0] & w_b_sh[GROUP-1:0];
    assign w_c       = cla_carries(w_p, w_g, r_carry);
    assign w_sum     = w_p ^ w_c[GROUP-1:0];
    assign w_acc_nxt = r_acc | (WIDTH'(w_sum) << w_base);
    assign w_last    = (r_idx == IDX_W'(NG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // start is only looked at in IDLE, so a request while busy leaves everything untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovr   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_c[GROUP];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_s    <= w_acc_nxt;
                        r_cout <= w_c[GROUP];
                        r_ovr  <= w_c[GROUP] ^ w_c[GROUP-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovr  = r_ovr;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
endmodule
